// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer driving the 8-bit compare/logic ALU over a valid/ready pair.
// Define ALU_SEQ_FLAGS_EN to add registered zero/negative flags to each response.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  input  logic [7:0]       alu_s_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [7:0]       rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             rsp_zero_o,
  output logic             rsp_neg_o,
`endif
  output logic             busy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  // Command FIFO
  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;
  cmd_t            head, wr_cmd;

  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);
  // Gated by rst so nothing is accepted while the block is held in reset.
  assign cmd_ready_o = ~rst & ~full;
  assign push   = cmd_valid_i & cmd_ready_o;
  assign head   = mem_q[rd_ptr_q];
  assign wr_cmd = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i, tag: cmd_tag_i};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Issue FSM and registered ALU / response outputs
  state_e           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic             zero_q, zero_d, neg_q, neg_d;
  logic             head_legal;

  assign head_legal = (head.op >= 4'd2) && (head.op <= 4'd11);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    tag_d       = tag_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            alu_ctrl_d = head.op;
            alu_a_d    = head.a;
            alu_b_d    = head.b;
            tag_d      = head.tag;
            state_d    = StExec;
          end else begin
            // Illegal opcodes never reach the ALU.
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_tag_d   = head.tag;
            rsp_err_d   = 1'b1;
            zero_d      = 1'b0;
            neg_d       = 1'b0;
            state_d     = StResp;
          end
        end
      end
      StExec: begin
        alu_ctrl_d  = 4'd0;
        alu_a_d     = 8'h00;
        alu_b_d     = 8'h00;
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_s_i;
        rsp_tag_d   = tag_q;
        rsp_err_d   = 1'b0;
        zero_d      = (alu_s_i == 8'h00);
        neg_d       = alu_s_i[7];
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      alu_ctrl_q  <= 4'd0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign alu_ctrl_o  = alu_ctrl_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != StIdle) || !empty;

`ifdef ALU_SEQ_FLAGS_EN
  assign rsp_zero_o = zero_q;
  assign rsp_neg_o  = neg_q;
`else
  logic unused_flags;
  assign unused_flags = zero_q ^ neg_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed cases plus randomized traffic against
// an in-order response model and a behavioural ALU.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [7:0]       cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [3:0]       alu_ctrl;
  logic [7:0]       alu_a, alu_b, alu_s;
  logic             rsp_valid, rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err, busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic             rsp_zero, rsp_neg;
`endif

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_tag_i   (cmd_tag),
    .alu_ctrl_o  (alu_ctrl),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_s_i     (alu_s),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_tag_o   (rsp_tag),
    .rsp_err_o   (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero_o  (rsp_zero),
    .rsp_neg_o   (rsp_neg),
`endif
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic legal(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd11);
  endfunction

  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      4'd2:    return a;
      4'd3:    return a + 8'd1;
      4'd4:    return a - 8'd1;
      4'd5:    return ($signed(a) < 0) ? a + 8'd1 : a;
      4'd6:    return ~(a | b);
      4'd7:    return a ^ b;
      4'd8:    return ~(a ^ b);
      4'd9:    return {7'd0, $signed(a) > $signed(b)};
      4'd10:   return {7'd0, $signed(a) < $signed(b)};
      4'd11:   return {7'd0, a == b};
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural ALU seen by the DUT
  assign alu_s = ref_alu(alu_ctrl, alu_a, alu_b);

  typedef struct {
    logic [3:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             e;
  logic             prev_stall = 1'b0;
  logic [7:0]       prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_err;

  // Compare process: every mid-cycle sample is checked against the in-order model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("rsp_hold_valid", rsp_valid, 1);
        chk("rsp_hold_data", rsp_data, prev_data);
        chk("rsp_hold_tag", rsp_tag, prev_tag);
        chk("rsp_hold_err", rsp_err, prev_err);
      end
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", rsp_valid, 0);
      end else if (rsp_valid) begin
        chk("rsp_data", rsp_data, exp_q[0].data);
        chk("rsp_tag", rsp_tag, exp_q[0].tag);
        chk("rsp_err", rsp_err, exp_q[0].err);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero", rsp_zero, !exp_q[0].err && exp_q[0].data == 8'h00);
        chk("rsp_neg", rsp_neg, !exp_q[0].err && exp_q[0].data[7]);
`endif
      end
      if (alu_ctrl != 4'd0) begin
        if (exp_q.size() == 0) begin
          fail("alu_without_cmd");
        end else begin
          chk("alu_ctrl", alu_ctrl, exp_q[0].op);
          chk("alu_a", alu_a, exp_q[0].a);
          chk("alu_b", alu_b, exp_q[0].b);
        end
      end else begin
        chk("alu_idle_a", alu_a, 0);
        chk("alu_idle_b", alu_b, 0);
      end
      if (exp_q.size() < DEPTH) chk("cmd_ready_free", cmd_ready, 1);
      else if (exp_q.size() == DEPTH + 1) chk("cmd_ready_full", cmd_ready, 0);
      chk("busy", busy, exp_q.size() != 0);

      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_tag   = rsp_tag;
      prev_err   = rsp_err;
      if (rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (cmd_valid && cmd_ready) begin
        e.op   = cmd_op;
        e.a    = cmd_a;
        e.b    = cmd_b;
        e.tag  = cmd_tag;
        e.err  = !legal(cmd_op);
        e.data = legal(cmd_op) ? ref_alu(cmd_op, cmd_a, cmd_b) : 8'h00;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [TAG_W-1:0] tag);
    logic ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) fail("send_timeout");
  endtask

  logic cap_zero, cap_neg;

  task automatic wait_rsp(output int lat, output logic [7:0] d, output logic [TAG_W-1:0] t,
                          output logic er, output logic [3:0] alu_or);
    logic got = 1'b0;
    lat    = 0;
    alu_or = 4'd0;
    d      = 8'h00;
    t      = '0;
    er     = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      alu_or |= alu_ctrl;
      if (rsp_valid) begin
        got = 1'b1;
        d   = rsp_data;
        t   = rsp_tag;
        er  = rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
        cap_zero = rsp_zero;
        cap_neg  = rsp_neg;
`endif
      end
      tick();
    end
    if (!got) fail("rsp_timeout");
  endtask

  int               lat, acc, got;
  logic [7:0]       d;
  logic [TAG_W-1:0] t;
  logic             er;
  logic [3:0]       alu_or;
  logic [3:0]       cmp_op  [4] = '{4'd9, 4'd10, 4'd11, 4'd5};
  logic [7:0]       cmp_a   [4] = '{8'hFF, 8'hFF, 8'h5A, 8'h80};
  logic [7:0]       cmp_b   [4] = '{8'h01, 8'h01, 8'h5A, 8'h00};
  logic [7:0]       cmp_exp [4] = '{8'h00, 8'h01, 8'h01, 8'h81};
  logic [3:0]       bp_op   [5] = '{4'd3, 4'd7, 4'd9, 4'd12, 4'd6};
  logic [TAG_W-1:0] bp_tag  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_tag = '0; rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    tick();

    // Single op, latency from acceptance
    send(4'd3, 8'h7F, 8'h00, 2'd1);
    wait_rsp(lat, d, t, er, alu_or);
    chk("single_latency", lat, 3);
    chk("single_data", d, 8'h80);
    chk("single_tag", t, 1);
    chk("single_err", er, 0);

    for (int i = 0; i < 4; i++) begin
      send(cmp_op[i], cmp_a[i], cmp_b[i], TAG_W'(i));
      wait_rsp(lat, d, t, er, alu_or);
      chk("cmp_data", d, cmp_exp[i]);
      chk("cmp_tag", t, i);
    end

    send(4'd13, 8'h33, 8'h44, 2'd2);
    wait_rsp(lat, d, t, er, alu_or);
    chk("illegal_data", d, 0);
    chk("illegal_err", er, 1);
    chk("illegal_tag", t, 2);
    chk("illegal_alu_idle", alu_or, 0);

`ifdef ALU_SEQ_FLAGS_EN
    send(4'd4, 8'h01, 8'h00, 2'd3);
    wait_rsp(lat, d, t, er, alu_or);
    chk("flag_data0", d, 8'h00);
    chk("flag_zero0", cap_zero, 1);
    chk("flag_neg0", cap_neg, 0);
    send(4'd4, 8'h00, 8'h00, 2'd0);
    wait_rsp(lat, d, t, er, alu_or);
    chk("flag_data1", d, 8'hFF);
    chk("flag_zero1", cap_zero, 0);
    chk("flag_neg1", cap_neg, 1);
`endif

    // Backpressure: exactly DEPTH+1 accepted
    rsp_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1; cmd_op = bp_op[0]; cmd_a = 8'h91; cmd_b = 8'h17; cmd_tag = bp_tag[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      tick();
      if (acc < 5) begin
        cmd_op = bp_op[acc]; cmd_tag = bp_tag[acc]; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      end else begin
        cmd_op = 4'd2; cmd_tag = 2'd1;
      end
    end
    @(negedge clk);
    chk("bp_accepted", acc, 5);
    chk("bp_ready_low", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        chk("bp_tag_order", rsp_tag, bp_tag[got]);
        got++;
      end
      tick();
    end
    if (got < 5) fail("bp_drain");

    // Reset while the second command executes with two still queued
    rsp_ready = 1'b0;
    send(4'd2, 8'h10, 8'h00, 2'd0);
    send(4'd3, 8'h20, 8'h00, 2'd1);
    send(4'd4, 8'h30, 8'h00, 2'd2);
    send(4'd6, 8'h40, 8'h0F, 2'd3);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      got = int'(rsp_valid);
      tick();
    end
    if (got == 0) fail("midrst_first_rsp");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_exec", alu_ctrl, 4'd3);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_alu_ctrl", alu_ctrl, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      chk("midrst_no_stale", rsp_valid, 0);
    end
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_op    = 4'($urandom_range(0, 15));
      cmd_a     = 8'($urandom);
      cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : 8'($urandom);
      cmd_tag   = TAG_W'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got == 0; c++) begin
      @(negedge clk);
      got = int'(!busy);
      tick();
    end
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_rsp_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks,
             failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
